// File: rtl/plru_array.sv
// plru_array: per-set tree pseudo-LRU replacement tracker for an N-way
// set-associative cache, with invalid-way preference and a sequenced flush.
//
// Ports:
//   clk_i           clock, all logic on the rising edge
//   rst_i           synchronous active-high reset
//   access_valid_i  a way of a set was touched (hit or fill) this cycle
//   access_set_i    set of the access
//   access_way_i    way touched
//   query_valid_i   victim request
//   query_set_i     set to choose a victim in
//   query_vmask_i   per-way valid bits of the queried set (1 = valid line)
//   victim_valid_o  victim_way_o carries a fresh answer this cycle
//   victim_way_o    chosen victim way (holds while victim_valid_o is low)
//   flush_i         start clearing all replacement state
//   busy_o          flush sweep in progress; accesses and queries are dropped
//
// Each set keeps NUM_WAYS-1 heap-indexed tree bits: node 0 is the root,
// node i has children 2i+1 (lower ways) and 2i+2 (upper ways). A bit of 0
// sends the victim walk left, 1 sends it right.

module plru_array #(
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 4,
  localparam int SET_W = $clog2(NUM_SETS),
  localparam int WAY_W = $clog2(NUM_WAYS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                access_valid_i,
  input  logic [SET_W-1:0]    access_set_i,
  input  logic [WAY_W-1:0]    access_way_i,
  input  logic                query_valid_i,
  input  logic [SET_W-1:0]    query_set_i,
  input  logic [NUM_WAYS-1:0] query_vmask_i,
  output logic                victim_valid_o,
  output logic [WAY_W-1:0]    victim_way_o,
  input  logic                flush_i,
  output logic                busy_o
);

  typedef logic [NUM_WAYS-2:0] tree_t;

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  state_t           state_q;
  logic [SET_W-1:0] flush_cnt_q;
  tree_t            tree_q [NUM_SETS];

  logic             access_ok;
  logic             query_ok;
  tree_t            query_bits;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] victim_next;

  // Walk from the root towards the touched leaf, pointing every node on the
  // path at the opposite subtree. Way bits are consumed MSB first, which is
  // the left/right decision at each successive level. The node index
  // computed after the last level is never used.
  function automatic tree_t touch(input tree_t bits, input logic [WAY_W-1:0] way);
    tree_t            r;
    logic [WAY_W-1:0] w;
    logic             dir;
    int               node;
    r    = bits;
    w    = way;
    node = 0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      dir               = w[WAY_W-1];
      r[node[WAY_W-1:0]] = ~dir;
      node              = 2 * node + 1 + int'(dir);
      w                 = w << 1;
    end
    return r;
  endfunction

  // Follow the tree bits from the root; each visited bit is the next way
  // index bit, MSB first.
  function automatic logic [WAY_W-1:0] walk(input tree_t bits);
    logic [WAY_W-1:0] w;
    logic             dir;
    int               node;
    w    = '0;
    node = 0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      dir  = bits[node[WAY_W-1:0]];
      w    = (w << 1) | WAY_W'(dir);
      node = 2 * node + 1 + int'(dir);
    end
    return w;
  endfunction

  // A flush in the same cycle as an access wins, so the access is dropped.
  assign access_ok = access_valid_i & ~busy_o & ~flush_i;
  assign query_ok  = query_valid_i & ~busy_o;

  // Victim selection: lowest-index invalid way first; otherwise walk the
  // tree of the queried set, including an accepted same-cycle access to
  // that set so the answer reflects the post-update state.
  always_comb begin
    logic [NUM_WAYS-1:0] mask;
    inv_found  = 1'b0;
    inv_way    = '0;
    mask       = query_vmask_i;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!mask[0] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
      mask = mask >> 1;
    end

    query_bits = tree_q[query_set_i];
    if (access_ok && (access_set_i == query_set_i)) begin
      query_bits = touch(query_bits, access_way_i);
    end

    victim_next = inv_found ? inv_way : walk(query_bits);
  end

  // State, flush sequencer and registered outputs. The sweep clears one set
  // per cycle, so busy_o stays high for exactly NUM_SETS cycles; flush_i
  // during the sweep is ignored.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tree_q         <= '{default: '0};
      state_q        <= IDLE;
      busy_o         <= 1'b0;
      flush_cnt_q    <= '0;
      victim_valid_o <= 1'b0;
      victim_way_o   <= '0;
    end else begin
      victim_valid_o <= query_ok;
      if (query_ok) begin
        victim_way_o <= victim_next;
      end

      case (state_q)
        IDLE: begin
          if (flush_i) begin
            state_q     <= SWEEP;
            busy_o      <= 1'b1;
            flush_cnt_q <= '0;
          end else if (access_ok) begin
            tree_q[access_set_i] <= touch(tree_q[access_set_i], access_way_i);
          end
        end
        SWEEP: begin
          tree_q[flush_cnt_q] <= '0;
          flush_cnt_q         <= flush_cnt_q + SET_W'(1);
          if (flush_cnt_q == SET_W'(NUM_SETS - 1)) begin
            state_q <= IDLE;
            busy_o  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plru_array.sv
// tb_plru_array: self-checking bench for plru_array with 8 sets and 4 ways.
// Directed table of single-cycle vectors, hand-written flush and
// reset-mid-flush sequences, then randomized traffic compared with a
// recency-based reference model.

module tb_plru_array;

  localparam int NS = 8;
  localparam int NW = 4;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          access_valid_i;
  logic [2:0]    access_set_i;
  logic [1:0]    access_way_i;
  logic          query_valid_i;
  logic [2:0]    query_set_i;
  logic [NW-1:0] query_vmask_i;
  logic          victim_valid_o;
  logic [1:0]    victim_way_o;
  logic          flush_i;
  logic          busy_o;

  int checks   = 0;
  int failures = 0;

  plru_array #(
    .NUM_SETS(NS),
    .NUM_WAYS(NW)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .access_valid_i(access_valid_i),
    .access_set_i  (access_set_i),
    .access_way_i  (access_way_i),
    .query_valid_i (query_valid_i),
    .query_set_i   (query_set_i),
    .query_vmask_i (query_vmask_i),
    .victim_valid_o(victim_valid_o),
    .victim_way_o  (victim_way_o),
    .flush_i       (flush_i),
    .busy_o        (busy_o)
  );

  // 100 MHz-style free-running clock.
  always #5 clk_i = ~clk_i;

  // Reference model: each set remembers when each way was last touched.
  // At every tree level the victim goes to the half that does not contain
  // the most recently touched way (left when neither half was touched).
  longint unsigned stamp [NS][NW];
  longint unsigned now_t = 0;
  int              m_busy = 0;
  logic            m_vv = 1'b0;
  int              m_way = 0;

  function automatic void clear_model();
    for (int s = 0; s < NS; s++)
      for (int w = 0; w < NW; w++)
        stamp[s][w] = 0;
  endfunction

  function automatic int model_victim(input int s, input logic [NW-1:0] vm);
    int              lo, size, half;
    longint unsigned lmax, rmax;
    for (int w = 0; w < NW; w++)
      if (vm[w] == 1'b0) return w;
    lo   = 0;
    size = NW;
    while (size > 1) begin
      half = size / 2;
      lmax = 0;
      rmax = 0;
      for (int i = lo; i < lo + half; i++)
        if (stamp[s][i] > lmax) lmax = stamp[s][i];
      for (int i = lo + half; i < lo + size; i++)
        if (stamp[s][i] > rmax) rmax = stamp[s][i];
      if (lmax > rmax) lo = lo + half;
      size = half;
    end
    return lo;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, then
  // settle 1 time unit past the edge so outputs can be sampled.
  task automatic applyStimulus(input logic av, input int as, input int aw,
                               input logic qv, input int qs, input logic [NW-1:0] vm,
                               input logic fl, input logic rs);
    access_valid_i = av;
    access_set_i   = 3'(as);
    access_way_i   = 2'(aw);
    query_valid_i  = qv;
    query_set_i    = 3'(qs);
    query_vmask_i  = vm;
    flush_i        = fl;
    rst_i          = rs;
    @(posedge clk_i);
    if (rs) begin
      clear_model();
      m_busy = 0;
      m_vv   = 1'b0;
      m_way  = 0;
    end else if (m_busy > 0) begin
      m_busy--;
      m_vv = 1'b0;
    end else begin
      if (av && !fl) begin
        now_t++;
        stamp[as][aw] = now_t;
      end
      if (qv) begin
        m_vv  = 1'b1;
        m_way = model_victim(qs, vm);
      end else begin
        m_vv = 1'b0;
      end
      if (fl) begin
        clear_model();
        m_busy = NS;
      end
    end
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 4'b1111, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, "_busy"}, int'(busy_o), (m_busy > 0) ? 1 : 0);
    checkOutput({tag, "_vv"}, int'(victim_valid_o), int'(m_vv));
    checkOutput({tag, "_way"}, int'(victim_way_o), m_way);
  endtask

  typedef struct {
    logic          av;
    int            as;
    int            aw;
    logic          qv;
    int            qs;
    logic [NW-1:0] vm;
    logic          exp_vv;
    int            exp_way;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int busy_cycles;
    int guard;

    tbl[0]  = '{1'b0, 0, 0, 1'b1, 3, 4'b1111, 1'b1, 0};
    tbl[1]  = '{1'b1, 5, 0, 1'b0, 0, 4'b1111, 1'b0, 0};
    tbl[2]  = '{1'b1, 5, 2, 1'b0, 0, 4'b1111, 1'b0, 0};
    tbl[3]  = '{1'b1, 5, 1, 1'b0, 0, 4'b1111, 1'b0, 0};
    tbl[4]  = '{1'b0, 0, 0, 1'b1, 5, 4'b1111, 1'b1, 3};
    tbl[5]  = '{1'b1, 5, 0, 1'b0, 0, 4'b1111, 1'b0, 3};
    tbl[6]  = '{1'b1, 5, 1, 1'b0, 0, 4'b1111, 1'b0, 3};
    tbl[7]  = '{1'b1, 5, 2, 1'b0, 0, 4'b1111, 1'b0, 3};
    tbl[8]  = '{1'b1, 5, 3, 1'b0, 0, 4'b1111, 1'b0, 3};
    tbl[9]  = '{1'b0, 0, 0, 1'b1, 5, 4'b1111, 1'b1, 0};
    tbl[10] = '{1'b0, 0, 0, 1'b1, 5, 4'b1011, 1'b1, 2};
    tbl[11] = '{1'b0, 0, 0, 1'b1, 5, 4'b0110, 1'b1, 0};
    tbl[12] = '{1'b1, 2, 0, 1'b1, 2, 4'b1111, 1'b1, 2};
    tbl[13] = '{1'b1, 1, 0, 1'b1, 6, 4'b1111, 1'b1, 0};
    tbl[14] = '{1'b0, 0, 0, 1'b1, 1, 4'b1111, 1'b1, 2};

    // Reset held for two cycles.
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 4'b1111, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 4'b1111, 1'b0, 1'b1);
    checkOutput("reset_busy", int'(busy_o), 0);
    checkOutput("reset_vv", int'(victim_valid_o), 0);
    checkOutput("reset_way", int'(victim_way_o), 0);

    // Directed vectors: access ordering, invalid preference, bypass, isolation.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(tbl[i].av, tbl[i].as, tbl[i].aw, tbl[i].qv, tbl[i].qs,
                    tbl[i].vm, 1'b0, 1'b0);
      checkOutput($sformatf("vec%0d_vv", i), int'(victim_valid_o), int'(tbl[i].exp_vv));
      checkOutput($sformatf("vec%0d_way", i), int'(victim_way_o), tbl[i].exp_way);
      checkOutput($sformatf("vec%0d_busy", i), int'(busy_o), 0);
    end

    // Flush: busy for exactly NS cycles, queries dropped meanwhile.
    applyStimulus(1'b1, 7, 0, 1'b0, 0, 4'b1111, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b1, 7, 4'b1111, 1'b0, 1'b0);
    checkOutput("pre_flush_way", int'(victim_way_o), 2);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 4'b1111, 1'b1, 1'b0);
    busy_cycles = 0;
    guard       = 0;
    while (busy_o && guard < 20) begin
      busy_cycles++;
      guard++;
      applyStimulus(1'b0, 0, 0, 1'b1, 7, 4'b1111, 1'b0, 1'b0);
      checkOutput("busy_query_vv", int'(victim_valid_o), 0);
    end
    checkOutput("flush_len", busy_cycles, NS);
    applyStimulus(1'b0, 0, 0, 1'b1, 7, 4'b1111, 1'b0, 1'b0);
    checkOutput("post_flush_vv", int'(victim_valid_o), 1);
    checkOutput("post_flush_way", int'(victim_way_o), 0);

    // Reset on the third busy cycle of a flush.
    applyStimulus(1'b1, 3, 1, 1'b0, 0, 4'b1111, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 0, 1'b1, 3, 4'b1111, 1'b0, 1'b0);
    checkOutput("pre_rst_way", int'(victim_way_o), 2);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 4'b1111, 1'b1, 1'b0);
    idle();
    idle();
    checkOutput("third_busy", int'(busy_o), 1);
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 4'b1111, 1'b0, 1'b1);
    checkOutput("midrst_busy", int'(busy_o), 0);
    checkOutput("midrst_vv", int'(victim_valid_o), 0);
    checkOutput("midrst_way", int'(victim_way_o), 0);
    for (int s = 0; s < NS; s++) begin
      applyStimulus(1'b0, 0, 0, 1'b1, s, 4'b1111, 1'b0, 1'b0);
      checkOutput($sformatf("midrst_set%0d_vv", s), int'(victim_valid_o), 1);
      checkOutput($sformatf("midrst_set%0d_way", s), int'(victim_way_o), 0);
    end
    applyStimulus(1'b0, 0, 0, 1'b0, 0, 4'b1111, 1'b1, 1'b0);
    busy_cycles = 0;
    guard       = 0;
    while (busy_o && guard < 20) begin
      busy_cycles++;
      guard++;
      idle();
    end
    checkOutput("reflush_len", busy_cycles, NS);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      logic          av, qv, fl, rs;
      logic [NW-1:0] vm;
      rs = ($urandom_range(0, 199) == 0);
      fl = ($urandom_range(0, 59) == 0);
      av = ($urandom_range(0, 9) < 6);
      qv = !fl && ($urandom_range(0, 9) < 6);
      vm = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom_range(0, 15));
      applyStimulus(av, $urandom_range(0, NS - 1), $urandom_range(0, NW - 1),
                    qv, $urandom_range(0, NS - 1), vm, fl, rs);
      checkModel($sformatf("rand%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
